// File: rtl/hclk_cycler.sv
// hclk_cycler
//
// Round-robin sequencer for a bank of HCLK divider channels. Each channel is
// a DHCEN clock gate feeding a CLKDIV; exactly one channel is enabled at a
// time for a programmable dwell period. Every switch is glitch-safe: the old
// clock is gated off, a guard interval elapses, then the next divider leaves
// reset and, after another guard interval, its clock gate opens.
//
// Ports
//   clk          in   input clock, all logic on the rising edge
//   rst_i        in   synchronous active-high reset
//   key_i        in   hold request; freezes the running channel (RUN only)
//   dwell_i      in   dwell length in clk cycles, sampled on RUN entry (0 -> 1)
//   ce_o         out  per-channel DHCEN CE, at most one bit set
//   div_rstn_o   out  per-channel CLKDIV RESETN (active-low), at most one set
//   sel_o        out  index of the current channel
//   switching_o  out  high whenever the sequencer is not in RUN
//   wrap_o       out  one-cycle pulse when sel_o wraps from NUM_HCLK-1 to 0
//
// Handshake: there is none; key_i is a level request sampled every rising
// edge while in RUN, and the response on ce_o appears after that same edge.
module hclk_cycler #(
    parameter int NUM_HCLK = 4,
    parameter int DWELL_W  = 26,
    parameter int GUARD    = 8,
    localparam int SEL_W   = (NUM_HCLK > 1) ? $clog2(NUM_HCLK) : 1,
    localparam int GW      = $clog2(GUARD + 1)
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                key_i,
    input  logic [DWELL_W-1:0]  dwell_i,
    output logic [NUM_HCLK-1:0] ce_o,
    output logic [NUM_HCLK-1:0] div_rstn_o,
    output logic [SEL_W-1:0]    sel_o,
    output logic                switching_o,
    output logic                wrap_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        STOP    = 2'd3
    } state_e;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_HCLK - 1);

    state_e                state_q;
    logic [NUM_HCLK-1:0]   ce_q;
    logic [NUM_HCLK-1:0]   rstn_q;
    logic [SEL_W-1:0]      sel_q;
    logic                  switching_q;
    logic                  wrap_q;
    logic [GW-1:0]         guard_q;
    logic [DWELL_W-1:0]    dwell_q;

    logic [SEL_W-1:0]      sel_d;
    logic [DWELL_W-1:0]    dwell_d;

    function automatic logic [NUM_HCLK-1:0] onehot(input logic [SEL_W-1:0] s);
        onehot = NUM_HCLK'(1) << s;
    endfunction

    always_comb begin
        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
        // A zero dwell would otherwise underflow; run the channel one cycle.
        dwell_d = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ce_q        <= '0;
            rstn_q      <= '0;
            sel_q       <= '0;
            switching_q <= 1'b1;
            wrap_q      <= 1'b0;
            guard_q     <= '0;
            dwell_q     <= '0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // RESETN only rises on the first RELEASE edge, so this
                    // entry needs one extra guard count compared with the
                    // entry from STOP, where RESETN rises on the entry edge.
                    state_q <= RELEASE;
                    guard_q <= GW'(GUARD);
                end

                RELEASE: begin
                    rstn_q <= onehot(sel_q);
                    ce_q   <= '0;
                    if (guard_q == '0) begin
                        state_q     <= RUN;
                        ce_q        <= onehot(sel_q);
                        switching_q <= 1'b0;
                        dwell_q     <= dwell_d;
                    end else begin
                        guard_q <= guard_q - GW'(1);
                    end
                end

                RUN: begin
                    if (key_i) begin
                        // Hold: gate the clock, keep the divider out of reset,
                        // freeze the dwell count.
                        ce_q <= '0;
                    end else if (dwell_q <= DWELL_W'(1)) begin
                        state_q     <= STOP;
                        ce_q        <= '0;
                        switching_q <= 1'b1;
                        guard_q     <= GW'(GUARD - 1);
                    end else begin
                        ce_q    <= onehot(sel_q);
                        dwell_q <= dwell_q - DWELL_W'(1);
                    end
                end

                STOP: begin
                    ce_q <= '0;
                    if (guard_q == '0) begin
                        // Old RESETN drops in the same edge the new one rises.
                        state_q <= RELEASE;
                        sel_q   <= sel_d;
                        rstn_q  <= onehot(sel_d);
                        wrap_q  <= (sel_q == SEL_LAST);
                        guard_q <= GW'(GUARD - 1);
                    end else begin
                        guard_q <= guard_q - GW'(1);
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    ce_q        <= '0;
                    rstn_q      <= '0;
                    switching_q <= 1'b1;
                end
            endcase
        end
    end

    assign ce_o        = ce_q;
    assign div_rstn_o  = rstn_q;
    assign sel_o       = sel_q;
    assign switching_o = switching_q;
    assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_hclk_cycler.sv
// Directed bench for hclk_cycler: a 4-channel/GUARD=8 instance and a
// 1-channel/GUARD=1 instance, checked cycle by cycle against hand-derived
// timelines (n counts rising edges since the first edge with reset low).
module tb_hclk_cycler;

    logic        clk;
    logic        rst_i;
    logic        key_i;
    logic [25:0] dwell_i;
    logic [3:0]  ce_o;
    logic [3:0]  div_rstn_o;
    logic [1:0]  sel_o;
    logic        switching_o;
    logic        wrap_o;

    logic        rst1;
    logic [25:0] dwell1;
    logic        ce1;
    logic        rstn1;
    logic        sel1;
    logic        sw1;
    logic        wrap1;

    int tests_run;
    int tests_failed;

    hclk_cycler #(.NUM_HCLK(4), .DWELL_W(26), .GUARD(8)) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .key_i       (key_i),
        .dwell_i     (dwell_i),
        .ce_o        (ce_o),
        .div_rstn_o  (div_rstn_o),
        .sel_o       (sel_o),
        .switching_o (switching_o),
        .wrap_o      (wrap_o)
    );

    hclk_cycler #(.NUM_HCLK(1), .DWELL_W(26), .GUARD(1)) dut1 (
        .clk         (clk),
        .rst_i       (rst1),
        .key_i       (1'b0),
        .dwell_i     (dwell1),
        .ce_o        (ce1),
        .div_rstn_o  (rstn1),
        .sel_o       (sel1),
        .switching_o (sw1),
        .wrap_o      (wrap1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {ce[3:0], rstn[3:0], sel[1:0], switching, wrap} after edge n
    // with no hold, effective dwell d, guard g, nh channels.
    function automatic logic [11:0] exp_vec(input int n, input int d, input int g, input int nh);
        logic [3:0] ce;
        logic [3:0] rstn;
        logic [1:0] sel;
        logic       on;
        logic       wr;
        int         per;
        int         p;
        int         o;
        if (n == 0) begin
            exp_vec = {4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0};
        end else begin
            per  = d + 2 * g;
            p    = (n - 1) / per;
            o    = (n - 1) % per;
            sel  = 2'(p % nh);
            rstn = 4'b0001 << sel;
            on   = (o >= g) && (o < g + d);
            ce   = on ? rstn : 4'b0000;
            wr   = (o == 0) && (p > 0) && (sel == 2'b00);
            exp_vec = {ce, rstn, sel, ~on, wr};
        end
    endfunction

    // Hold reset for a few cycles, release it at a falling edge.
    task automatic restart_main();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] act;
        logic [11:0] exp;
        rst_i   = 1'b1;
        key_i   = 1'b1;
        dwell_i = 26'd20;
        repeat (3) @(posedge clk);
        @(negedge clk);
        act = {ce_o, div_rstn_o, sel_o, switching_o, wrap_o};
        exp = {4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL reset got=%b exp=%b", act, exp);
        end
        key_i = 1'b0;
    endtask

    task automatic test_startup_round_robin();
        logic [11:0] act;
        logic [11:0] exp;
        logic [1:0]  sel_seq [0:4];
        logic [1:0]  sel_exp [0:4];
        int          wraps;
        sel_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        wraps   = 0;
        dwell_i = 26'd20;
        restart_main();
        for (int n = 0; n <= 145; n++) begin
            @(posedge clk);
            @(negedge clk);
            act = {ce_o, div_rstn_o, sel_o, switching_o, wrap_o};
            exp = exp_vec(n, 20, 8, 4);
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("FAIL startup_rr n=%0d got=%b exp=%b", n, act, exp);
            end
            if (wrap_o === 1'b1) wraps++;
            if (n >= 1 && ((n - 1) % 36) == 0) sel_seq[(n - 1) / 36] = sel_o;
        end
        tests_run++;
        if (wraps != 1) begin
            tests_failed++;
            $display("FAIL wrap_count got=%0d exp=1", wraps);
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (sel_seq[i] !== sel_exp[i]) begin
                tests_failed++;
                $display("FAIL sel_seq[%0d] got=%0d exp=%0d", i, sel_seq[i], sel_exp[i]);
            end
        end
    endtask

    // Hold for 5 cycles mid-RUN on channel 0, key during STOP and RELEASE
    // (ignored), and a dwell change during RUN that only affects channel 1.
    task automatic test_hold();
        logic [11:0] act;
        logic [11:0] exp;
        logic [3:0]  ce;
        logic [3:0]  rstn;
        logic [1:0]  sel;
        logic        run;
        dwell_i = 26'd20;
        restart_main();
        for (int n = 0; n <= 66; n++) begin
            key_i = ((n >= 15 && n <= 19) || (n >= 35 && n <= 41) || (n >= 43 && n <= 50));
            if (n == 25) dwell_i = 26'd5;
            @(posedge clk);
            @(negedge clk);
            sel  = (n < 42) ? 2'd0 : (n < 63) ? 2'd1 : 2'd2;
            rstn = (n == 0) ? 4'b0000 : (4'b0001 << sel);
            run  = (n >= 9 && n <= 33) || (n >= 50 && n <= 54);
            ce   = ((n >= 9 && n <= 14) || (n >= 20 && n <= 33) || (n >= 50 && n <= 54)) ? rstn : 4'b0000;
            exp  = {ce, rstn, sel, ~run, 1'b0};
            act  = {ce_o, div_rstn_o, sel_o, switching_o, wrap_o};
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("FAIL hold n=%0d got=%b exp=%b", n, act, exp);
            end
        end
        key_i   = 1'b0;
        dwell_i = 26'd20;
    endtask

    task automatic test_zero_dwell();
        logic [11:0] act;
        logic [11:0] exp;
        dwell_i = 26'd0;
        restart_main();
        for (int n = 0; n <= 70; n++) begin
            @(posedge clk);
            @(negedge clk);
            act = {ce_o, div_rstn_o, sel_o, switching_o, wrap_o};
            exp = exp_vec(n, 1, 8, 4);
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("FAIL zero_dwell n=%0d got=%b exp=%b", n, act, exp);
            end
        end
        dwell_i = 26'd20;
    endtask

    task automatic test_reset_mid_run();
        logic [11:0] act;
        logic [11:0] exp;
        dwell_i = 26'd20;
        restart_main();
        for (int n = 0; n <= 84; n++) begin
            @(posedge clk);
            @(negedge clk);
            act = {ce_o, div_rstn_o, sel_o, switching_o, wrap_o};
            exp = exp_vec(n, 20, 8, 4);
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("FAIL pre_reset n=%0d got=%b exp=%b", n, act, exp);
            end
        end
        // Channel 2 is in RUN here; one reset edge must clear everything.
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        act = {ce_o, div_rstn_o, sel_o, switching_o, wrap_o};
        exp = {4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL mid_reset got=%b exp=%b", act, exp);
        end
        rst_i = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            act = {ce_o, div_rstn_o, sel_o, switching_o, wrap_o};
            exp = exp_vec(n, 20, 8, 4);
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("FAIL restart n=%0d got=%b exp=%b", n, act, exp);
            end
        end
    endtask

    task automatic test_single_channel();
        logic [11:0] act;
        logic [11:0] exp;
        int          wraps;
        wraps  = 0;
        dwell1 = 26'd3;
        rst1   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst1 = 1'b0;
        for (int n = 0; n <= 21; n++) begin
            @(posedge clk);
            @(negedge clk);
            act = {3'b000, ce1, 3'b000, rstn1, 1'b0, sel1, sw1, wrap1};
            exp = exp_vec(n, 3, 1, 1);
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("FAIL single_ch n=%0d got=%b exp=%b", n, act, exp);
            end
            if (wrap1 === 1'b1) wraps++;
        end
        // Wraps after edges 6, 11, 16, 21.
        tests_run++;
        if (wraps != 4) begin
            tests_failed++;
            $display("FAIL single_ch_wraps got=%0d exp=4", wraps);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_i        = 1'b1;
        key_i        = 1'b0;
        dwell_i      = 26'd20;
        rst1         = 1'b1;
        dwell1       = 26'd3;
        test_reset();
        test_startup_round_robin();
        test_hold();
        test_zero_dwell();
        test_reset_mid_run();
        test_single_channel();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
